// File: rtl/msg_word16_sender_pkg.sv
// rtl/msg_word16_sender_pkg.sv - shared messaging constants, state encoding and message IDs
package msg_word16_sender_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h55;
    localparam int         MSG_ID_WIDTH      = 8;

    // Encoding is shared with the receive-side router; keep values stable.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_ID   = 3'd2,
        ST_LO   = 3'd3,
        ST_HI   = 3'd4,
        ST_CSUM = 3'd5,
        ST_DONE = 3'd6
    } msg_state_e;

    localparam logic [7:0] MSG_ID_PING   = 8'h01;
    localparam logic [7:0] MSG_ID_WORD   = 8'h02;
    localparam logic [7:0] MSG_ID_STATUS = 8'h12;

endpackage

// File: rtl/msg_checksum8.sv
// rtl/msg_checksum8.sv - modulo-256 sum of the three checksummed frame bytes
module msg_checksum8 (
    input  logic [7:0] id_byte,
    input  logic [7:0] lo_byte,
    input  logic [7:0] hi_byte,
    output logic [7:0] sum
);

    assign sum = id_byte + lo_byte + hi_byte;

endmodule

// File: rtl/msg_word16_sender.sv
// rtl/msg_word16_sender.sv - frames one 16-bit word as SYNC, ID, LO, HI, CSUM bytes
module msg_word16_sender
    import msg_word16_sender_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         MSG_ID_W  = MSG_ID_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [MSG_ID_W-1:0] msg_id,
    input  logic [15:0]         data_word,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                busy,
    output logic                done
);

    msg_state_e          state_q, state_d;
    logic [MSG_ID_W-1:0] id_q;
    logic [15:0]         data_q;
    logic [7:0]          csum;
    logic                handshake;

    logic [7:0] byte_d;
    logic       valid_d, busy_d, done_d;

    assign handshake = byte_valid && byte_ready;

    msg_checksum8 u_csum (
        .id_byte (id_q),
        .lo_byte (data_q[7:0]),
        .hi_byte (data_q[15:8]),
        .sum     (csum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)     state_d = ST_SYNC;
            ST_SYNC: if (handshake) state_d = ST_ID;
            ST_ID:   if (handshake) state_d = ST_LO;
            ST_LO:   if (handshake) state_d = ST_HI;
            ST_HI:   if (handshake) state_d = ST_CSUM;
            ST_CSUM: if (handshake) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        byte_d  = 8'h00;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_d)
            ST_SYNC: begin byte_d = SYNC_BYTE;     valid_d = 1'b1; busy_d = 1'b1; end
            ST_ID:   begin byte_d = id_q;          valid_d = 1'b1; busy_d = 1'b1; end
            ST_LO:   begin byte_d = data_q[7:0];   valid_d = 1'b1; busy_d = 1'b1; end
            ST_HI:   begin byte_d = data_q[15:8];  valid_d = 1'b1; busy_d = 1'b1; end
            ST_CSUM: begin byte_d = csum;          valid_d = 1'b1; busy_d = 1'b1; end
            ST_DONE: done_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q   <= '0;
            data_q <= 16'h0000;
        end else if (state_q == ST_IDLE && start) begin
            id_q   <= msg_id;
            data_q <= data_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            byte_out   <= byte_d;
            byte_valid <= valid_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_msg_word16_sender.sv
// tb/tb_msg_word16_sender.sv - directed self-checking bench for msg_word16_sender
module tb_msg_word16_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  msg_id = 8'h00;
    logic [15:0] data_word = 16'h0000;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b0;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    msg_word16_sender dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .msg_id     (msg_id),
        .data_word  (data_word),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, " valid"}, {31'd0, byte_valid}, 32'd0);
        check_eq({tag, " busy"},  {31'd0, busy},       32'd0);
        check_eq({tag, " done"},  {31'd0, done},       32'd0);
        check_eq({tag, " byte"},  {24'd0, byte_out},   32'd0);
    endtask

    // Called at a negedge; returns at the negedge of the cycle showing SYNC.
    task automatic send_start(input logic [7:0] id, input logic [15:0] data);
        start     = 1'b1;
        msg_id    = id;
        data_word = data;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Checks five frame bytes with byte_ready high, then the Done cycle.
    // At byte index 'disturb' a stray Start plus new inputs are driven for one cycle.
    task automatic check_stream(input string tag, input logic [7:0] exp [5], input int disturb);
        byte_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("%s b%0d valid", tag, i), {31'd0, byte_valid}, 32'd1);
            check_eq($sformatf("%s b%0d busy", tag, i),  {31'd0, busy},       32'd1);
            check_eq($sformatf("%s b%0d byte", tag, i),  {24'd0, byte_out},   {24'd0, exp[i]});
            if (i == disturb) begin
                start     = 1'b1;
                msg_id    = 8'hEE;
                data_word = 16'h1111;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_eq({tag, " done"},       {31'd0, done},       32'd1);
        check_eq({tag, " done valid"}, {31'd0, byte_valid}, 32'd0);
        check_eq({tag, " done busy"},  {31'd0, busy},       32'd0);
        check_eq({tag, " done byte"},  {24'd0, byte_out},   32'd0);
    endtask

    logic [7:0] exp_bytes [5];

    initial begin
        #2;
        check_idle("reset async");
        repeat (2) @(negedge clk);
        check_idle("reset held");
        rst = 1'b0;
        @(negedge clk);
        byte_ready = 1'b1;
        @(negedge clk);
        check_idle("ready while idle");

        // Basic frame
        send_start(8'h12, 16'hABCD);
        exp_bytes = '{8'h55, 8'h12, 8'hCD, 8'hAB, 8'h8A};
        check_stream("basic", exp_bytes, -1);
        @(negedge clk);
        check_idle("basic after");

        // Backpressure during LO
        send_start(8'h01, 16'h00FF);
        check_eq("bp sync", {24'd0, byte_out}, 32'h55);
        @(negedge clk);
        check_eq("bp id", {24'd0, byte_out}, 32'h01);
        @(negedge clk);
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("bp hold%0d byte", i),  {24'd0, byte_out},   32'hFF);
            check_eq($sformatf("bp hold%0d valid", i), {31'd0, byte_valid}, 32'd1);
            @(negedge clk);
        end
        exp_bytes = '{8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};
        byte_ready = 1'b1;
        check_eq("bp resume lo", {24'd0, byte_out}, 32'hFF);
        @(negedge clk);
        check_eq("bp hi", {24'd0, byte_out}, 32'h00);
        @(negedge clk);
        check_eq("bp csum", {24'd0, byte_out}, 32'h00);
        check_eq("bp csum valid", {31'd0, byte_valid}, 32'd1);
        @(negedge clk);
        check_eq("bp done", {31'd0, done}, 32'd1);
        @(negedge clk);

        // Checksum wrap
        send_start(8'hFF, 16'hFFFF);
        exp_bytes = '{8'h55, 8'hFF, 8'hFF, 8'hFF, 8'hFD};
        check_stream("wrap", exp_bytes, -1);
        @(negedge clk);

        // Stray Start and input change while busy
        send_start(8'h33, 16'h1234);
        exp_bytes = '{8'h55, 8'h33, 8'h34, 8'h12, 8'h79};
        check_stream("ignore", exp_bytes, 2);
        repeat (2) begin
            @(negedge clk);
            check_idle("ignore after");
        end

        // Reset mid-frame during HI
        send_start(8'h44, 16'h5566);
        repeat (3) @(negedge clk);
        check_eq("rst pre hi byte", {24'd0, byte_out}, 32'h55);
        #2 rst = 1'b1;
        #1;
        check_idle("rst mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("rst released");
        send_start(8'h02, 16'h0304);
        exp_bytes = '{8'h55, 8'h02, 8'h04, 8'h03, 8'h09};
        check_stream("post rst", exp_bytes, -1);

        // Back-to-back: Start in the cycle after Done
        @(negedge clk);
        send_start(8'h10, 16'h0203);
        exp_bytes = '{8'h55, 8'h10, 8'h03, 8'h02, 8'h15};
        check_stream("b2b", exp_bytes, -1);
        @(negedge clk);
        check_idle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
